// File: rtl/riscv_defines.sv
// Shared core definitions: trap request record, trap sequencer states and
// the machine-mode CSR addresses the sequencer writes.
package riscv_defines;

  typedef enum logic [1:0] {
    TRAP_ENTER  = 2'b00,
    TRAP_RETURN = 2'b01
  } trap_mode_t;

  // mode stays a raw 2-bit field so undefined encodings survive capture and
  // can be treated as trap entry downstream.
  typedef struct packed {
    logic        valid;
    logic [1:0]  mode;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_req_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    WR_EPC,
    WR_CAUSE,
    WR_TVAL,
    REDIRECT
  } trap_state_t;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

endpackage

// File: rtl/trap_vector_calc.sv
// Trap entry target: mtvec base, plus 4*code for interrupts in vectored mode.
module trap_vector_calc (
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  output logic [31:0] target
);

  logic [31:0] base;
  logic [31:0] offset;

  assign base   = {mtvec[31:2], 2'b00};
  // Interrupt code shifted into a word offset; the top code bit falls off.
  assign offset = 32'({cause[30:0], 2'b00});
  assign target = (mtvec[1:0] == 2'b01 && cause[31]) ? base + offset : base;

endmodule

// File: rtl/trap_controller.sv
// Trap entry / mret sequencer: drain memory traffic, write mepc/mcause/mtval,
// then redirect fetch. Flush and fetch stall are held for the whole sequence.
module trap_controller
  import riscv_defines::*;
#(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        start,
  input  trap_req_t   trap_req_w,
  input  logic        mem_pending,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_trap_enter,
  output logic        csr_trap_return,
  output logic        flush_all,
  output logic        stall_f,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  trap_state_t      state_reg, state_next;
  logic [1:0]       mode_reg;
  logic [31:0]      cause_reg, pc_reg, tval_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      vec_target;
  logic             is_return;
  logic             drain_done;

  assign is_return  = (mode_reg == TRAP_RETURN);
  assign drain_done = !mem_pending || (cnt_reg == CNT_W'(DRAIN_TIMEOUT - 1));

  trap_vector_calc u_vec (
    .mtvec  (csr_mtvec),
    .cause  (cause_reg),
    .target (vec_target)
  );

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_reg <= IDLE;
      mode_reg  <= '0;
      cause_reg <= '0;
      pc_reg    <= '0;
      tval_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Requests are only accepted from IDLE; anything later is a squashed
      // younger instruction.
      if (state_reg == IDLE && trap_req_w.valid) begin
        mode_reg  <= trap_req_w.mode;
        cause_reg <= trap_req_w.cause;
        pc_reg    <= trap_req_w.pc;
        tval_reg  <= trap_req_w.tval;
        cnt_reg   <= '0;
      end else if (state_reg == DRAIN) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    csr_we          = 1'b0;
    csr_waddr       = '0;
    csr_wdata       = '0;
    csr_trap_enter  = 1'b0;
    csr_trap_return = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    case (state_reg)
      IDLE: begin
        if (trap_req_w.valid) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = is_return ? REDIRECT : WR_EPC;
      end
      WR_EPC: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MEPC;
        csr_wdata  = pc_reg & 32'hFFFF_FFFC;
        state_next = WR_CAUSE;
      end
      WR_CAUSE: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MCAUSE;
        csr_wdata  = cause_reg;
        state_next = WR_TVAL;
      end
      WR_TVAL: begin
        csr_we         = 1'b1;
        csr_waddr      = CSR_MTVAL;
        csr_wdata      = tval_reg;
        csr_trap_enter = 1'b1;
        state_next     = REDIRECT;
      end
      REDIRECT: begin
        // CSR inputs are read here so an mepc written moments ago is seen.
        redirect_valid  = 1'b1;
        csr_trap_return = is_return;
        redirect_pc     = is_return ? (csr_mepc & 32'hFFFF_FFFC) : vec_target;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign flush_all = busy;
  assign stall_f   = busy;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: expected CSR writes and redirects are
// queued when a request is issued and matched as the sequencer emits them.
module tb_trap_controller;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        start;
  trap_req_t   req;
  logic        mem_pending;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_trap_enter, csr_trap_return;
  logic        flush_all, stall_f, redirect_valid, busy;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk             (clk),
    .start           (start),
    .trap_req_w      (req),
    .mem_pending     (mem_pending),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .csr_we          (csr_we),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata),
    .csr_trap_enter  (csr_trap_enter),
    .csr_trap_return (csr_trap_return),
    .flush_all       (flush_all),
    .stall_f         (stall_f),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  // flags = {csr_we, redirect_valid, csr_trap_enter, csr_trap_return}
  typedef struct {
    logic [3:0]  flags;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic any_out();
    return |{csr_we, csr_waddr, csr_wdata, csr_trap_enter, csr_trap_return,
             flush_all, stall_f, redirect_valid, redirect_pc, busy};
  endfunction

  task automatic push(input logic [3:0] f, input logic [11:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.flags = f;
    e.addr  = a;
    e.data  = d;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic push_enter(input int n0, input int d, input logic [31:0] pc,
                            input logic [31:0] cause, input logic [31:0] tval,
                            input logic [31:0] target);
    push(4'b1000, 12'h341, pc & 32'hFFFF_FFFC, n0 + 2 + d);
    push(4'b1000, 12'h342, cause,              n0 + 3 + d);
    push(4'b1010, 12'h343, tval,               n0 + 4 + d);
    push(4'b0100, 12'h000, target,             n0 + 5 + d);
  endtask

  task automatic issue(input logic [1:0] mode, input logic [31:0] cause,
                       input logic [31:0] pc, input logic [31:0] tval, output int n0);
    req.valid = 1'b1;
    req.mode  = mode;
    req.cause = cause;
    req.pc    = pc;
    req.tval  = tval;
    n0 = cyc;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (csr_we || redirect_valid || csr_trap_enter || csr_trap_return) begin
      $display("cyc %0d: we=%b addr=%h wdata=%h enter=%b return=%b redirect=%b pc=%h",
               cyc, csr_we, csr_waddr, csr_wdata, csr_trap_enter, csr_trap_return,
               redirect_valid, redirect_pc);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_event observed=%b%b%b%b expected=none at cyc %0d",
               csr_we, redirect_valid, csr_trap_enter, csr_trap_return, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("event_flags", 64'({csr_we, redirect_valid, csr_trap_enter, csr_trap_return}), 64'(e.flags));
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        chk("event_addr", 64'(csr_waddr), 64'(e.addr));
        if (e.flags[2]) chk("redirect_pc", 64'(redirect_pc), 64'(e.data));
        else            chk("csr_wdata", 64'(csr_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_within_budget", 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    start       = 1'b0;
    req         = '0;
    mem_pending = 1'b0;
    csr_mtvec   = 32'h0000_0200;
    csr_mepc    = 32'h0;
    #2;
    chk("reset_outputs", 64'(any_out()), 64'(0));
    tick();
    tick();
    start = 1'b1;
    tick();
    chk("idle_after_release", 64'(any_out()), 64'(0));

    // Illegal instruction with flush window check
    issue(TRAP_ENTER, 32'd2, 32'h0000_0104, 32'hFFFF_FFFF, n);
    push_enter(n, 0, 32'h0000_0104, 32'd2, 32'hFFFF_FFFF, 32'h0000_0200);
    #1;
    chk("capture_cycle_quiet", 64'(any_out()), 64'(0));
    tick();
    req.valid = 1'b0;
    chk("flush_first", 64'({flush_all, stall_f, busy}), 64'(3'b111));
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("flush_window", 64'({flush_all, stall_f, busy}), 64'(3'b111));
    end
    tick();
    chk("flush_released", 64'({flush_all, stall_f, busy}), 64'(3'b000));

    // Vectored interrupt, misaligned pc
    csr_mtvec = 32'h0000_0201;
    issue(TRAP_ENTER, 32'h8000_0007, 32'h0000_1003, 32'h55, n);
    push_enter(n, 0, 32'h0000_1003, 32'h8000_0007, 32'h55, 32'h0000_021C);
    tick();
    req.valid = 1'b0;
    wait_idle(10);

    // Exception under vectored mtvec, unknown mode acts as entry
    issue(2'b11, 32'd5, 32'h0000_2000, 32'hAB, n);
    push_enter(n, 0, 32'h0000_2000, 32'd5, 32'hAB, 32'h0000_0200);
    tick();
    req.valid = 1'b0;
    wait_idle(10);

    // mret
    csr_mtvec = 32'h0000_0200;
    csr_mepc  = 32'h0000_0300;
    issue(TRAP_RETURN, 32'h0, 32'h0, 32'h0, n);
    push(4'b0101, 12'h000, 32'h0000_0300, n + 2);
    tick();
    req.valid = 1'b0;
    wait_idle(10);

    csr_mepc = 32'h0000_0413;
    issue(TRAP_RETURN, 32'h0, 32'h0, 32'h0, n);
    push(4'b0101, 12'h000, 32'h0000_0410, n + 2);
    tick();
    req.valid = 1'b0;
    wait_idle(10);

    // mem_pending high for three cycles
    mem_pending = 1'b1;
    issue(TRAP_ENTER, 32'd4, 32'h0000_0400, 32'h404, n);
    push_enter(n, 2, 32'h0000_0400, 32'd4, 32'h404, 32'h0000_0200);
    tick();
    req.valid = 1'b0;
    tick();
    tick();
    mem_pending = 1'b0;
    wait_idle(20);

    // mem_pending stuck high: drain timeout
    mem_pending = 1'b1;
    issue(TRAP_ENTER, 32'd6, 32'h0000_0500, 32'h0, n);
    push_enter(n, 15, 32'h0000_0500, 32'd6, 32'h0, 32'h0000_0200);
    tick();
    req.valid = 1'b0;
    wait_idle(40);
    mem_pending = 1'b0;

    // Second request during WR_CAUSE is ignored
    issue(TRAP_ENTER, 32'd3, 32'h0000_0600, 32'h77, n);
    push_enter(n, 0, 32'h0000_0600, 32'd3, 32'h77, 32'h0000_0200);
    tick();
    req.valid = 1'b0;
    tick();
    tick();
    req.valid = 1'b1;
    req.mode  = TRAP_RETURN;
    req.cause = 32'd9;
    req.pc    = 32'h0000_0900;
    req.tval  = 32'h99;
    tick();
    req.valid = 1'b0;
    wait_idle(10);
    for (int i = 0; i < 4; i++) tick();

    // Reset during WR_CAUSE, then a clean sequence
    issue(TRAP_ENTER, 32'd11, 32'h0000_0700, 32'h88, n);
    push(4'b1000, 12'h341, 32'h0000_0700, n + 2);
    push(4'b1000, 12'h342, 32'd11,        n + 3);
    tick();
    req.valid = 1'b0;
    tick();
    tick();
    #2;
    start = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'(any_out()), 64'(0));
    chk("reset_mid_busy", 64'(busy), 64'(0));
    tick();
    tick();
    chk("reset_held_outputs", 64'(any_out()), 64'(0));
    start = 1'b1;
    issue(TRAP_ENTER, 32'd1, 32'h0000_0800, 32'h12, n);
    push_enter(n, 0, 32'h0000_0800, 32'd1, 32'h12, 32'h0000_0200);
    tick();
    req.valid = 1'b0;
    wait_idle(10);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Multi-cycle sequencer that takes the committed trap request (trap_req_t) leaving writeback and performs the architectural trap entry or mret return.
- Trap entry: flushes the pipeline, waits for outstanding data-memory traffic to drain, writes mepc/mcause/mtval one per cycle through the CSR file write port, then redirects fetch.
- mret: drain, then redirect to mepc.
- Its flush and stall outputs feed the hazard unit, which ORs them into the hazard_bus flush/stall responses of every stage.

Parameters:
- DRAIN_TIMEOUT, 16: maximum cycles spent in DRAIN before proceeding regardless of mem_pending.
- CNT_W, 5: width of the drain counter; must hold DRAIN_TIMEOUT.

Ports:
- clk  input  1  system clock
- start  input  1  asynchronous active-low reset; the core is held in reset while low
- trap_req_w  input  trap_req_t  committed trap request {valid, mode, cause, pc, tval}
- mem_pending  input  1  a data-memory transaction is outstanding
- csr_mtvec  input  32  current mtvec value
- csr_mepc  input  32  current mepc value
- csr_we  output  1  CSR write strobe
- csr_waddr  output  12  CSR address: 0x341 mepc, 0x342 mcause, 0x343 mtval
- csr_wdata  output  32  CSR write data
- csr_trap_enter  output  1  one-cycle pulse; the CSR file does MPIE<=MIE, MIE<=0, MPP<=M
- csr_trap_return  output  1  one-cycle pulse; the CSR file does MIE<=MPIE, MPIE<=1
- flush_all  output  1  flush request to all pipeline stages
- stall_f  output  1  hold fetch
- redirect_valid  output  1  one-cycle pulse: fetch loads redirect_pc
- redirect_pc  output  32  redirect target
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values (start low, asynchronous): state IDLE, captured request cleared, drain counter 0, every output 0.
- States: IDLE, DRAIN, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT.
- IDLE:
  - trap_req_w.valid=1 captures mode, cause, pc and tval into internal registers, clears the drain counter and goes to DRAIN.
  - Outputs are all 0 while in IDLE, including the capture cycle.
- DRAIN:
  - Counter increments each cycle.
  - Leave when mem_pending=0 or counter==DRAIN_TIMEOUT-1, whichever comes first.
  - Next state: WR_EPC if mode=TRAP_ENTER, REDIRECT if mode=TRAP_RETURN.
- WR_EPC: csr_we=1, waddr 0x341, wdata = captured pc with bits [1:0] forced to 0.
- WR_CAUSE: csr_we=1, waddr 0x342, wdata = captured cause.
- WR_TVAL: csr_we=1, waddr 0x343, wdata = captured tval. Assert csr_trap_enter in this same cycle.
- REDIRECT:
  - redirect_valid=1 for one cycle, then return to IDLE.
  - ENTER target: if csr_mtvec[1:0]==2'b01 and cause[31]==1, target = {mtvec[31:2],2'b00} + (cause[30:0]<<2), truncated to 32 bits. Otherwise target = {mtvec[31:2],2'b00}.
  - RETURN target: {csr_mepc[31:2],2'b00}, with csr_trap_return=1 in the same cycle.
  - csr_mtvec and csr_mepc are sampled in REDIRECT itself, so the WR_EPC write is visible to mret-after-trap sequences.
- flush_all, stall_f and busy are 1 in every non-IDLE state, REDIRECT included.
- Enter latency with mem_pending=0: valid in cycle N; DRAIN N+1; WR_EPC N+2; WR_CAUSE N+3; WR_TVAL N+4; REDIRECT N+5. Return latency: redirect at N+2.
- Any trap_req_w.valid arriving while busy is ignored; the flush guarantees it is a squashed younger instruction.
- Unknown mode values behave as TRAP_ENTER.
- If start falls mid-sequence, the FSM returns to IDLE immediately with no partial CSR write completing. Writes already issued stay.
- csr_we, redirect_valid, csr_trap_enter and csr_trap_return are mutually exclusive, except csr_we and csr_trap_enter in WR_TVAL.

Decomposition:
- riscv_defines package:
  - trap_state_t enum for the FSM states.
  - CSR address constants CSR_MEPC, CSR_MCAUSE, CSR_MTVAL.
  - TRAP_RETURN, alongside the existing TRAP_ENTER.
  - Reuse the existing trap_req_t.
- One sub-module, trap_vector_calc: combinational mtvec/cause to target computation, tested standalone.

Test Plan:
- Illegal instruction, pc=0x0000_0104, tval=0xFFFF_FFFF, mtvec=0x0000_0200, mem_pending=0:
  - WR_EPC writes 0x104, WR_CAUSE writes 2, WR_TVAL writes 0xFFFF_FFFF.
  - redirect_pc=0x200 at N+5; flush_all high N+1..N+5.
- Vectored interrupt: cause=0x8000_0007, mtvec=0x0000_0201 -> redirect_pc=0x0000_021C.
- mret with csr_mepc=0x0000_0300 -> csr_trap_return and redirect_valid at N+2, redirect_pc=0x300, csr_we never asserted.
- mem_pending held high for 3 cycles -> DRAIN lasts 3 cycles and WR_EPC starts the cycle mem_pending falls. With mem_pending stuck high -> exit after exactly DRAIN_TIMEOUT=16 cycles.
- Second trap_req_w.valid pulse during WR_CAUSE -> ignored: one redirect only, captured values unchanged.
- start driven low during WR_CAUSE -> same cycle all outputs 0 and busy=0. After release, the next valid request starts cleanly from IDLE.
